// File: rtl/xor_stream_pkg.sv
// Shared types and default sizes for the XOR stream accumulator slice.
package xor_stream_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    // ACCUM gathers words of a burst; HOLD presents the finished result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/xor_stream_accumulator_xor_vec.sv
// Bitwise XOR of two vectors composed purely of 2:1 multiplexer cells.
// Each bit first forms NOT a with a mux selecting between constants, then
// picks a or NOT a depending on b, which is exactly a XOR b.

module mux2_cell (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module xor_vec_using_mux
    import xor_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] a_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_cell u_inv (
            .sel (a[i]),
            .d0  (1'b1),
            .d1  (1'b0),
            .y   (a_n[i])
        );
        mux2_cell u_xor (
            .sel (b[i]),
            .d0  (a[i]),
            .d1  (a_n[i]),
            .y   (y[i])
        );
    end
endmodule

// File: rtl/xor_stream_accumulator.sv
// Accumulates the XOR of every word in an upstream burst, counts the words
// (saturating), and presents the result with parity on a downstream
// valid/ready port. Result fields are captured into dedicated registers when
// the last word arrives, so outputs never depend combinationally on inputs.
module xor_stream_accumulator
    import xor_stream_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    output logic             up_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    output logic             down_parity,
    output logic [CNT_W-1:0] down_count,
    input  logic             down_ready
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_par_q, res_par_d;

    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             up_fire;
    logic             down_fire;

    xor_vec_using_mux #(
        .WIDTH (WIDTH)
    ) u_xor (
        .a (acc_q),
        .b (up_data),
        .y (acc_next)
    );

    assign cnt_next  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign up_fire   = up_valid && (state_q == ACCUM);
    assign down_fire = down_ready && (state_q == HOLD);

    // Next-state logic: fold accepted words in, capture the result on the last
    // word, and clear the accumulator once the result has been taken.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        res_par_d  = res_par_q;
        if (up_fire) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            if (up_last) begin
                res_data_d = INVERT ? ~acc_next : acc_next;
                res_par_d  = (^acc_next) ^ INVERT;
                res_cnt_d  = cnt_next;
                state_d    = HOLD;
            end
        end else if (down_fire) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
        end
    end

    // State and result registers; reset wins over any handshake in the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_cnt_q  <= '0;
            res_par_q  <= INVERT;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            res_par_q  <= res_par_d;
        end
    end

    assign up_ready    = (state_q == ACCUM);
    assign down_valid  = (state_q == HOLD);
    assign down_data   = res_data_q;
    assign down_parity = res_par_q;
    assign down_count  = res_cnt_q;

endmodule

// File: tb/tb_xor_stream_accumulator.sv
// Self-checking bench for xor_stream_accumulator. A default instance
// (WIDTH=8, CNT_W=8, INVERT=0) is scoreboarded against a small reference
// model; a second instance (CNT_W=2, INVERT=1) covers saturation and XNOR mode.
module tb_xor_stream_accumulator;

    typedef struct packed {
        logic [7:0] data;
        logic       parity;
        logic [7:0] count;
    } exp_t;

    localparam logic [7:0] B2B_WORDS [6] = '{8'hA1, 8'hB2, 8'hC3, 8'h44, 8'h05, 8'h06};
    localparam bit         B2B_LASTS [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       up_valid = 1'b0;
    logic [7:0] up_data = 8'h00;
    logic       up_last = 1'b0;
    logic       up_ready;
    logic       down_valid;
    logic [7:0] down_data;
    logic       down_parity;
    logic [7:0] down_count;
    logic       down_ready = 1'b0;

    logic       b_up_valid = 1'b0;
    logic [7:0] b_up_data = 8'h00;
    logic       b_up_last = 1'b0;
    logic       b_up_ready;
    logic       b_down_valid;
    logic [7:0] b_down_data;
    logic       b_down_parity;
    logic [1:0] b_down_count;
    logic       b_down_ready = 1'b0;

    exp_t       exp_q[$];
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    int         n_compared = 0;
    int         n_mismatched = 0;

    xor_stream_accumulator #(
        .WIDTH  (8),
        .CNT_W  (8),
        .INVERT (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_last     (up_last),
        .up_ready    (up_ready),
        .down_valid  (down_valid),
        .down_data   (down_data),
        .down_parity (down_parity),
        .down_count  (down_count),
        .down_ready  (down_ready)
    );

    xor_stream_accumulator #(
        .WIDTH  (8),
        .CNT_W  (2),
        .INVERT (1'b1)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .up_valid    (b_up_valid),
        .up_data     (b_up_data),
        .up_last     (b_up_last),
        .up_ready    (b_up_ready),
        .down_valid  (b_down_valid),
        .down_data   (b_down_data),
        .down_parity (b_down_parity),
        .down_count  (b_down_count),
        .down_ready  (b_down_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: fold a word into the running burst and push the
    // expected result when the burst ends.
    task automatic model_word(input logic [7:0] d, input logic last);
        exp_t e;
        m_acc = m_acc ^ d;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (last) begin
            e.data   = m_acc;
            e.parity = ^m_acc;
            e.count  = m_cnt;
            exp_q.push_back(e);
            m_acc = 8'h00;
            m_cnt = 8'h00;
        end
    endtask

    // Offer one word for a single cycle while the DUT is known to be accumulating.
    task automatic send(input logic [7:0] d, input logic last);
        @(negedge clk);
        up_valid = 1'b1;
        up_data  = d;
        up_last  = last;
        model_word(d, last);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_last  = 1'b0;
        up_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for down_valid; cycles = -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (down_valid !== 1'b1 && cycles < 20);
        if (down_valid !== 1'b1) cycles = -1;
    endtask

    task automatic release_result;
        @(negedge clk);
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        down_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if (up_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_up_ready: got %b want 1", up_ready); end
        n_compared++;
        if (down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_down_valid: got %b want 0", down_valid); end
        n_compared++;
        if (down_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_down_data: got %h want 00", down_data); end
        n_compared++;
        if (down_count !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_down_count: got %h want 00", down_count); end
        n_compared++;
        if (down_parity !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_down_parity: got %b want 0", down_parity); end
        n_compared++;
        if (b_down_parity !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_inv_parity: got %b want 1", b_down_parity); end
        n_compared++;
        if (b_down_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_inv_data: got %h want 00", b_down_data); end
        n_compared++;
        if ({b_up_ready, b_down_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL reset_inv_handshake: got %b want 10", {b_up_ready, b_down_valid}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        exp_t e, got;
        int cyc;
        send(8'hA5, 1'b1);
        wait_valid(cyc);
        n_compared++;
        if (cyc != 1) begin n_mismatched++; $display("[TB] FAIL single_latency: got %0d cycles want 1", cyc); end
        e   = exp_q.pop_front();
        got = {down_data, down_parity, down_count};
        n_compared++;
        if (got !== e) begin n_mismatched++; $display("[TB] FAIL single_result: got %h want %h", got, e); end
        n_compared++;
        if (up_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_hold_ready: got %b want 0", up_ready); end
        release_result();
        @(negedge clk);
        n_compared++;
        if ({up_ready, down_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL single_return: got %b want 10", {up_ready, down_valid}); end
    endtask

    task automatic test_gaps;
        exp_t e, got;
        int cyc;
        send(8'h3C, 1'b0);
        idle(2);
        send(8'h0F, 1'b0);
        idle(2);
        send(8'hFF, 1'b1);
        wait_valid(cyc);
        e   = exp_q.pop_front();
        got = {down_data, down_parity, down_count};
        n_compared++;
        if (cyc < 0 || got !== e) begin n_mismatched++; $display("[TB] FAIL gaps_result: got %h want %h (cycles %0d)", got, e, cyc); end
        release_result();
    endtask

    task automatic test_hold_stall;
        exp_t e, got;
        int cyc;
        send(8'h5A, 1'b0);
        send(8'hC3, 1'b1);
        wait_valid(cyc);
        e   = exp_q.pop_front();
        got = {down_data, down_parity, down_count};
        n_compared++;
        if (cyc < 0 || got !== e) begin n_mismatched++; $display("[TB] FAIL stall_result: got %h want %h", got, e); end
        for (int i = 0; i < 5; i++) begin
            up_valid = 1'b1;
            up_data  = 8'($urandom);
            up_last  = 1'($urandom);
            @(negedge clk);
            got = {down_data, down_parity, down_count};
            n_compared++;
            if ({down_valid, up_ready, got} !== {1'b1, 1'b0, e}) begin
                n_mismatched++;
                $display("[TB] FAIL stall_stable_%0d: got %b/%b/%h want 1/0/%h", i, down_valid, up_ready, got, e);
            end
        end
        up_valid = 1'b0;
        up_last  = 1'b0;
        release_result();
        send(8'h11, 1'b1);
        wait_valid(cyc);
        e   = exp_q.pop_front();
        got = {down_data, down_parity, down_count};
        n_compared++;
        if (cyc < 0 || got !== e) begin n_mismatched++; $display("[TB] FAIL stall_no_consume: got %h want %h", got, e); end
        release_result();
    endtask

    task automatic test_reset_midburst;
        exp_t e, got;
        int cyc;
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_acc = 8'h00;
        m_cnt = 8'h00;
        send(8'h01, 1'b1);
        wait_valid(cyc);
        e   = exp_q.pop_front();
        got = {down_data, down_parity, down_count};
        n_compared++;
        if (cyc < 0 || got !== e) begin n_mismatched++; $display("[TB] FAIL midburst_result: got %h want %h", got, e); end
        release_result();

        // Reset while a result is pending, with down_ready also high.
        send(8'h22, 1'b1);
        wait_valid(cyc);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst        = 1'b1;
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        down_ready = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({up_ready, down_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL hold_reset_state: got %b want 10", {up_ready, down_valid}); end
        n_compared++;
        if ({down_data, down_count} !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL hold_reset_result: got %h want 0000", {down_data, down_count}); end

        // Reset beats a simultaneous last-word handshake.
        rst      = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'hF0;
        up_last  = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        up_valid = 1'b0;
        up_last  = 1'b0;
        @(negedge clk);
        n_compared++;
        if (down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_priority: got down_valid %b want 0", down_valid); end
        send(8'h03, 1'b1);
        wait_valid(cyc);
        e   = exp_q.pop_front();
        got = {down_data, down_parity, down_count};
        n_compared++;
        if (cyc < 0 || got !== e) begin n_mismatched++; $display("[TB] FAIL reset_priority_next: got %h want %h", got, e); end
        release_result();
    endtask

    task automatic test_saturate_invert;
        logic [7:0] acc;
        int         cnt;
        int         cyc;
        logic [10:0] want, got;
        acc = 8'h00;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_up_valid = 1'b1;
            b_up_data  = 8'h01;
            b_up_last  = (i == 4);
            acc = acc ^ 8'h01;
            if (cnt < 3) cnt++;
            @(posedge clk);
            #1;
            b_up_valid = 1'b0;
            b_up_last  = 1'b0;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (b_down_valid !== 1'b1 && cyc < 20);
        want = {~acc, (^acc) ^ 1'b1, 2'(cnt)};
        got  = {b_down_data, b_down_parity, b_down_count};
        n_compared++;
        if (b_down_valid !== 1'b1 || got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL saturate_invert: got %h valid %b want %h", got, b_down_valid, want);
        end
        @(negedge clk);
        b_down_ready = 1'b1;
        @(posedge clk);
        #1;
        b_down_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e, got;
        int idx, low, seen, cyc;
        idx  = 0;
        low  = 0;
        seen = 0;
        cyc  = 0;
        down_ready = 1'b1;
        while ((idx < 6 || exp_q.size() > 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (down_valid === 1'b1) begin
                seen++;
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_extra: got result %h with none expected", down_data);
                end else begin
                    e   = exp_q.pop_front();
                    got = {down_data, down_parity, down_count};
                    if (got !== e) begin n_mismatched++; $display("[TB] FAIL b2b_result_%0d: got %h want %h", seen, got, e); end
                end
            end
            if (up_ready !== 1'b1) low++;
            if (up_ready === 1'b1 && idx < 6) begin
                up_valid = 1'b1;
                up_data  = B2B_WORDS[idx];
                up_last  = B2B_LASTS[idx];
                model_word(B2B_WORDS[idx], B2B_LASTS[idx]);
                idx++;
            end else if (idx < 6) begin
                up_valid = 1'b1;
                up_data  = 8'($urandom);
                up_last  = 1'($urandom);
            end else begin
                up_valid = 1'b0;
                up_last  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        down_ready = 1'b0;
        up_valid   = 1'b0;
        n_compared++;
        if (seen != 3) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d results want 3", seen); end
        n_compared++;
        if (low != 3) begin n_mismatched++; $display("[TB] FAIL b2b_ready_low: got %0d cycles want 3", low); end
        @(negedge clk);
        n_compared++;
        if (down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_drained: got down_valid %b want 0", down_valid); end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_hold_stall();
        test_reset_midburst();
        test_saturate_invert();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
